// File: rtl/pakout_ser_if.sv
// rtl/pakout_ser_if.sv - message and packet channel bundle for pakout_ser (o0_par present with PAKOUT_SER_PARITY_EN)
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 4
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 2
`endif

interface pakout_ser_if #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE,
    parameter int PSZ = `NS_PACKET_SIZE
);
    logic [ASZ-1:0] i0_src;
    logic [ASZ-1:0] i0_dst;
    logic [DSZ-1:0] i0_dat;
    logic [RSZ-1:0] i0_red;
    logic           i0_req_in;
    logic           i0_ack_out;
    logic [PSZ-1:0] o0_pakio;
    logic           o0_sop;
    logic           o0_req_out;
    logic           o0_ack_in;
    logic           busy;
`ifdef PAKOUT_SER_PARITY_EN
    logic           o0_par;
`endif

    modport master (
        output i0_src, i0_dst, i0_dat, i0_red, i0_req_in, o0_ack_in,
        input  i0_ack_out, o0_pakio, o0_sop, o0_req_out, busy
`ifdef PAKOUT_SER_PARITY_EN
        , input o0_par
`endif
    );

    modport slave (
        input  i0_src, i0_dst, i0_dat, i0_red, i0_req_in, o0_ack_in,
        output i0_ack_out, o0_pakio, o0_sop, o0_req_out, busy
`ifdef PAKOUT_SER_PARITY_EN
        , output o0_par
`endif
    );
endinterface

// File: rtl/pakout_ser.sv
// rtl/pakout_ser.sv - message-to-packet serializer over four-phase channels (optional o0_par via PAKOUT_SER_PARITY_EN)
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 4
`endif
`ifndef NS_ACK_CKS
`define NS_ACK_CKS 2
`endif

module pakout_ser #(
    parameter int ASZ     = `NS_ADDRESS_SIZE,
    parameter int DSZ     = `NS_DATA_SIZE,
    parameter int RSZ     = `NS_REDUN_SIZE,
    parameter int PSZ     = `NS_PACKET_SIZE,
    parameter int ACK_CKS = `NS_ACK_CKS
) (
    input  logic        src_clk,
    input  logic        reset,
    pakout_ser_if.slave bus
);
    localparam int FULL    = 2*ASZ + DSZ + RSZ;
    localparam int TOT_PKS = (FULL + PSZ - 1) / PSZ;
    localparam int TW      = TOT_PKS * PSZ;
    localparam int PADW    = TW - FULL;
    localparam int IW      = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1;
    localparam int ACKS    = (ACK_CKS < 1) ? 1 : ACK_CKS;
    localparam int CW      = $clog2(ACKS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(TOT_PKS - 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(ACKS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAITLO} state_t;

    state_t         state_q;
    logic [TW-1:0]  msg_q;
    logic [IW-1:0]  idx_q;
    logic           ack_out_q;
    logic           req_q;
    logic           busy_q;
    logic [PSZ-1:0] pakio_q;
    logic           sop_q;
    logic           sync1_q;
    logic           sync2_q;
    logic           filt_q;
    logic [CW-1:0]  cnt_q;
`ifdef PAKOUT_SER_PARITY_EN
    logic           par_q;
`endif

    logic [TW-1:0]  w_pad_d;
    logic [PSZ-1:0] slice_d;

    // Message sits left-justified so packet 0 always carries the top of src.
    assign w_pad_d = TW'({bus.i0_src, bus.i0_dst, bus.i0_dat, bus.i0_red}) << PADW;
    assign slice_d = msg_q[TW - 1 - int'(idx_q)*PSZ -: PSZ];

    // Consumer may run on another clock: synchronize, then require ACKS
    // consecutive disagreeing samples before the filtered ack flips.
    always_ff @(posedge src_clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= bus.o0_ack_in;
            sync2_q <= sync1_q;
            if (sync2_q != filt_q) begin
                if (cnt_q == CNT_TOP) begin
                    filt_q <= sync2_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge src_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            msg_q     <= '0;
            idx_q     <= '0;
            ack_out_q <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            pakio_q   <= '0;
            sop_q     <= 1'b0;
`ifdef PAKOUT_SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            // Message-side release runs regardless of packet progress.
            if (ack_out_q && !bus.i0_req_in) begin
                ack_out_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.i0_req_in && !ack_out_q) begin
                        msg_q     <= w_pad_d;
                        ack_out_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    pakio_q <= slice_d;
                    sop_q   <= (idx_q == '0);
`ifdef PAKOUT_SER_PARITY_EN
                    par_q   <= ^slice_d;
`endif
                    state_q <= SEND;
                end
                SEND: begin
                    // req rises one cycle after data, giving the setup margin.
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (filt_q) begin
                        req_q   <= 1'b0;
                        state_q <= WAITLO;
                    end
                end
                WAITLO: begin
                    if (!filt_q) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.i0_ack_out = ack_out_q;
    assign bus.o0_pakio   = pakio_q;
    assign bus.o0_sop     = sop_q;
    assign bus.o0_req_out = req_q;
    assign bus.busy       = busy_q;
`ifdef PAKOUT_SER_PARITY_EN
    assign bus.o0_par     = par_q;
`endif
endmodule

// File: tb/tb_pakout_ser.sv
// tb/tb_pakout_ser.sv - directed scoreboard bench for pakout_ser
module tb_pakout_ser;
    localparam int ASZ = 6, DSZ = 4, RSZ = 4, PSZ = 4, ACK_CKS = 2;
    localparam int FULL = 2*ASZ + DSZ + RSZ;
    localparam int TOT  = (FULL + PSZ - 1) / PSZ;
    localparam int TW   = TOT * PSZ;

    typedef struct {
        logic [PSZ-1:0] pak;
        logic           sop;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n;
    pkt_t exp_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   hs_done = 0;

    always #5 clk = ~clk;

    pakout_ser_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .PSZ(PSZ)) bus();

    pakout_ser #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .PSZ(PSZ), .ACK_CKS(ACK_CKS)) dut (
        .src_clk (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_msg(input logic [ASZ-1:0] src, input logic [ASZ-1:0] dst,
                           input logic [DSZ-1:0] dat, input logic [RSZ-1:0] red,
                           input int exp_hs);
        logic [TW-1:0] w;
        int t;
        w = TW'({src, dst, dat, red}) << (TW - FULL);
        for (int k = 0; k < TOT; k++) begin
            exp_q.push_back('{pak: w[TW-1-k*PSZ -: PSZ], sop: (k == 0)});
        end
        @(negedge clk);
        bus.i0_src = src; bus.i0_dst = dst; bus.i0_dat = dat; bus.i0_red = red;
        bus.i0_req_in = 1'b1;
        t = 0;
        while (bus.i0_ack_out !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        check("msg_ack_rise", bus.i0_ack_out, 1);
        check("hs_before_capture", hs_done, exp_hs);
        bus.i0_req_in = 1'b0;
        t = 0;
        while (bus.i0_ack_out !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        check("msg_ack_fall", bus.i0_ack_out, 0);
    endtask

    task automatic serve(input int n, input int stall_idx, input int glitch_idx);
        pkt_t e;
        int   t;
        logic ok;
        for (int k = 0; k < n; k++) begin
            t = 0;
            while (bus.o0_req_out !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
            check("pkt_req_rise", bus.o0_req_out, 1);
            check("busy_during_pkt", bus.busy, 1);
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '{pak: 'x, sop: 'x};
            check("pakio", bus.o0_pakio, e.pak);
            check("sop", bus.o0_sop, e.sop);
`ifdef PAKOUT_SER_PARITY_EN
            check("par", bus.o0_par, ^e.pak);
`endif
            if (k == glitch_idx) begin
                bus.o0_ack_in = 1'b1;
                @(negedge clk);
                bus.o0_ack_in = 1'b0;
                repeat (8) @(negedge clk);
                check("glitch_req_held", bus.o0_req_out, 1);
                check("glitch_pak_held", bus.o0_pakio, e.pak);
            end
            if (k == stall_idx) begin
                ok = 1'b1;
                repeat (100) begin
                    @(negedge clk);
                    if (bus.o0_pakio !== e.pak || bus.o0_sop !== e.sop || bus.o0_req_out !== 1'b1)
                        ok = 1'b0;
                end
                check("stall_stable", ok, 1);
            end
            bus.o0_ack_in = 1'b1;
            t = 0;
            while (bus.o0_req_out !== 1'b0 && t < 50) begin @(negedge clk); t++; end
            check("pkt_req_fall", bus.o0_req_out, 0);
            check("pak_hold_waitlo", bus.o0_pakio, e.pak);
            bus.o0_ack_in = 1'b0;
            hs_done++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (bus.busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        check(tag, bus.busy, 0);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        bus.i0_src = '0; bus.i0_dst = '0; bus.i0_dat = '0; bus.i0_red = '0;
        bus.i0_req_in = 1'b0; bus.o0_ack_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack_out", bus.i0_ack_out, 0);
        check("rst_req_out", bus.o0_req_out, 0);
        check("rst_pakio", bus.o0_pakio, 0);
        check("rst_sop", bus.o0_sop, 0);
        check("rst_busy", bus.busy, 0);
`ifdef PAKOUT_SER_PARITY_EN
        check("rst_par", bus.o0_par, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single message, expects 0,C,1,5,F
        hs_done = 0;
        fork
            put_msg(6'd3, 6'd1, 4'd5, 4'd15, 0);
            serve(5, -1, -1);
        join
        wait_idle("busy_drop_single");

        // back-to-back: second capture waits for all five handshakes of the first
        hs_done = 0;
        fork
            begin
                put_msg(6'h2A, 6'h15, 4'hA, 4'h3, 0);
                put_msg(6'h3F, 6'h00, 4'h6, 4'h9, 5);
            end
            serve(10, -1, -1);
        join
        wait_idle("busy_drop_b2b");

        // one-cycle ack glitch on packet 1
        hs_done = 0;
        fork
            put_msg(6'h11, 6'h22, 4'h7, 4'h8, 0);
            serve(5, -1, 1);
        join
        wait_idle("busy_drop_glitch");

        // 100-cycle stall on packet 3
        hs_done = 0;
        fork
            put_msg(6'h05, 6'h30, 4'hC, 4'h1, 0);
            serve(5, 3, -1);
        join
        wait_idle("busy_drop_stall");

        // asynchronous reset while packet 2 is requested
        hs_done = 0;
        fork
            put_msg(6'h1B, 6'h2C, 4'h3, 4'hD, 0);
            serve(2, -1, -1);
        join
        t = 0;
        while (bus.o0_req_out !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        check("pk2_req_before_rst", bus.o0_req_out, 1);
        rst_n = 1'b0;
        #1;
        check("arst_req_out", bus.o0_req_out, 0);
        check("arst_pakio", bus.o0_pakio, 0);
        check("arst_sop", bus.o0_sop, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_ack_out", bus.i0_ack_out, 0);
        exp_q.delete();
        bus.o0_ack_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        hs_done = 0;
        fork
            put_msg(6'd3, 6'd1, 4'd5, 4'd15, 0);
            serve(5, -1, -1);
        join
        wait_idle("busy_drop_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
